// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared types and defaults for the two-port shared-ALU arbiter.
// Revision : 1.0
// ============================================================================
package alu_arb_pkg;

    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_SELW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Combinational two-way round-robin pick; a tie goes to the
//            requester that was not served last.
// Revision : 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_ptr,
    output logic gnt_idx,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        gnt_idx = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ~last_ptr;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one external combinational ALU between two requesters
//            with a three-state IDLE/EXEC/DONE handshake.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = alu_arb_pkg::c_DEF_WIDTH,
    parameter int SELW  = alu_arb_pkg::c_DEF_SELW
) (
    input  logic             pCLK,
    input  logic             pRST,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [SELW-1:0]  sel0,
    input  logic [SELW-1:0]  sel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_s,
    output logic             busy
);

    import alu_arb_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_idx;
    logic               r_last;
    logic               w_win_idx;
    logic               w_any_req;
    logic               w_accept;
    logic               w_capture;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [SELW-1:0]    r_alu_sel;
    logic [WIDTH-1:0]   r_res0;
    logic [WIDTH-1:0]   r_res1;

    rr_arbiter2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_ptr (r_last),
        .gnt_idx  (w_win_idx),
        .any_req  (w_any_req)
    );

    always_ff @(posedge pCLK) begin
        if (pRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests are only looked at in IDLE; EXEC and DONE always advance.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                gnt0        = ~r_idx;
                gnt1        = r_idx;
                w_state_nxt = DONE;
            end
            DONE: begin
                done0       = ~r_idx;
                done1       = r_idx;
                w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pointer resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge pCLK) begin
        if (pRST) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_res0    <= '0;
            r_res1    <= '0;
            r_idx     <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_idx  <= w_win_idx;
                r_last <= w_win_idx;
                if (w_win_idx) begin
                    r_alu_a   <= a1;
                    r_alu_b   <= b1;
                    r_alu_sel <= sel1;
                end else begin
                    r_alu_a   <= a0;
                    r_alu_b   <= b0;
                    r_alu_sel <= sel0;
                end
            end
            if (w_capture) begin
                if (r_idx) begin
                    r_res1 <= alu_s;
                end else begin
                    r_res0 <= alu_s;
                end
            end
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_sel = r_alu_sel;
    assign res0    = r_res0;
    assign res1    = r_res1;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with an XOR stand-in ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int SELW  = 4;

    typedef struct {
        logic             idx;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic             pCLK = 1'b0;
    logic             pRST = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [SELW-1:0]  sel0 = '0, sel1 = '0;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] res0, res1, alu_a, alu_b, alu_s;
    logic [SELW-1:0]  alu_sel;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    assign alu_s = alu_a ^ alu_b;

    always #5 pCLK = ~pCLK;
    always @(posedge pCLK) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(WIDTH), .SELW(SELW)) dut (
        .pCLK(pCLK), .pRST(pRST), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_s(alu_s), .busy(busy)
    );

    task automatic tick();
        @(posedge pCLK);
        #1;
    endtask

    task automatic do_reset();
        pRST = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        pRST = 1'b0;
    endtask

    task automatic wait_done(output logic idx, output bit ok);
        ok  = 1'b0;
        idx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0 || done1) begin
                idx = done1;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, gnt0, gnt1, done0, done1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 00000", {busy, gnt0, gnt1, done0, done1});
        end
        total++;
        if ({alu_a, alu_b, alu_sel} !== '0) begin
            bad++;
            $display("FAIL reset_alu: got a=%h b=%h sel=%h want 0", alu_a, alu_b, alu_sel);
        end
        total++;
        if (res0 !== '0 || res1 !== '0) begin
            bad++;
            $display("FAIL reset_res: got res0=%h res1=%h want 0", res0, res1);
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        req0 = 1'b1; a0 = 32'h0000_00F0; b0 = 32'h0000_000F; sel0 = 4'h2;
        sb_q.push_back('{1'b0, a0 ^ b0});
        tick();
        req0 = 1'b0;
        total++;
        if ({gnt0, gnt1, busy, done0, alu_sel} !== {4'b1010, 4'h2}) begin
            bad++;
            $display("FAIL single_exec: got gnt0=%b gnt1=%b busy=%b done0=%b sel=%h want 1 0 1 0 2",
                     gnt0, gnt1, busy, done0, alu_sel);
        end
        tick();
        e = sb_q.pop_front();
        total++;
        if ({done0, done1, gnt0} !== 3'b100 || res0 !== e.res || res1 !== '0) begin
            bad++;
            $display("FAIL single_done: got done0=%b done1=%b gnt0=%b res0=%h res1=%h want 1 0 0 %h 0",
                     done0, done1, gnt0, res0, res1, e.res);
        end
        tick();
        total++;
        if ({done0, busy} !== 2'b00 || res0 !== e.res) begin
            bad++;
            $display("FAIL single_idle: got done0=%b busy=%b res0=%h want 0 0 %h", done0, busy, res0, e.res);
        end
    endtask

    task automatic test_tie();
        exp_t e;
        logic idx;
        bit   ok;
        int   last_cyc;
        do_reset();
        a0 = 32'hA5A5_0000; b0 = 32'h0000_5A5A; sel0 = 4'h1;
        a1 = 32'h0F0F_0F0F; b1 = 32'h1111_1111; sel1 = 4'h7;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{k[0], (k[0] ? (a1 ^ b1) : (a0 ^ b0))});
        end
        req0 = 1'b1; req1 = 1'b1;
        last_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            wait_done(idx, ok);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            e = sb_q.pop_front();
            total++;
            if (!ok || (done0 && done1) || idx !== e.idx) begin
                bad++;
                $display("FAIL tie_order[%0d]: got ok=%0d idx=%b done=%b%b want idx=%b", k, ok, idx, done1, done0, e.idx);
            end
            total++;
            if ((e.idx ? res1 : res0) !== e.res) begin
                bad++;
                $display("FAIL tie_res[%0d]: got %h want %h", k, (e.idx ? res1 : res0), e.res);
            end
            if (last_cyc >= 0) begin
                total++;
                if (cyc - last_cyc != 3) begin
                    bad++;
                    $display("FAIL tie_interval[%0d]: got %0d want 3", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
        end
        tick();
        total++;
        if ({done0, done1, busy} !== 3'b000) begin
            bad++;
            $display("FAIL tie_end: got done=%b%b busy=%b want 000", done1, done0, busy);
        end
    endtask

    task automatic test_operand_hold();
        exp_t e;
        do_reset();
        req1 = 1'b1; a1 = 32'h1234_5678; b1 = 32'h0; sel1 = 4'h5;
        sb_q.push_back('{1'b1, a1 ^ b1});
        tick();
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin
            bad++;
            $display("FAIL hold_gnt: got gnt1=%b gnt0=%b want 1 0", gnt1, gnt0);
        end
        req1 = 1'b0; a1 = 32'hFFFF_FFFF; sel1 = 4'hF;
        tick();
        e = sb_q.pop_front();
        total++;
        if (done1 !== 1'b1 || res1 !== e.res || res0 !== '0) begin
            bad++;
            $display("FAIL hold_res: got done1=%b res1=%h res0=%h want 1 %h 0", done1, res1, res0, e.res);
        end
        tick();
    endtask

    task automatic test_late_req();
        exp_t e;
        do_reset();
        req0 = 1'b1; a0 = 32'h0000_1111; b0 = 32'h0000_2222;
        a1 = 32'hCAFE_0000; b1 = 32'h0000_BEEF;
        sb_q.push_back('{1'b0, a0 ^ b0});
        sb_q.push_back('{1'b1, a1 ^ b1});
        tick();
        req0 = 1'b0; req1 = 1'b1;
        tick();
        e = sb_q.pop_front();
        total++;
        if ({done0, gnt1, done1} !== 3'b100 || res0 !== e.res) begin
            bad++;
            $display("FAIL late_first: got done0=%b gnt1=%b done1=%b res0=%h want 1 0 0 %h", done0, gnt1, done1, res0, e.res);
        end
        tick();
        total++;
        if ({gnt1, busy} !== 2'b00) begin
            bad++;
            $display("FAIL late_idle: got gnt1=%b busy=%b want 0 0", gnt1, busy);
        end
        tick();
        req1 = 1'b0;
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin
            bad++;
            $display("FAIL late_gnt: got gnt1=%b gnt0=%b want 1 0", gnt1, gnt0);
        end
        tick();
        e = sb_q.pop_front();
        total++;
        if (done1 !== 1'b1 || res1 !== e.res) begin
            bad++;
            $display("FAIL late_res: got done1=%b res1=%h want 1 %h", done1, res1, e.res);
        end
        tick();
    endtask

    task automatic test_reset_exec();
        exp_t e;
        logic idx;
        bit   ok;
        int   seen;
        do_reset();
        req0 = 1'b1; a0 = 32'h5555_0000; b0 = 32'h0000_AAAA;
        tick();
        req0 = 1'b0;
        pRST = 1'b1;
        tick();
        pRST = 1'b0;
        total++;
        if ({busy, gnt0, done0} !== 3'b000) begin
            bad++;
            $display("FAIL rexec_abort: got busy=%b gnt0=%b done0=%b want 000", busy, gnt0, done0);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0 || done1) seen++;
        end
        total++;
        if (seen != 0 || res0 !== '0 || res1 !== '0) begin
            bad++;
            $display("FAIL rexec_nores: got dones=%0d res0=%h res1=%h want 0 0 0", seen, res0, res1);
        end
        a1 = 32'h0000_0001; b1 = 32'h0000_0002;
        sb_q.push_back('{1'b0, a0 ^ b0});
        req0 = 1'b1; req1 = 1'b1;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL rexec_tie: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        wait_done(idx, ok);
        e = sb_q.pop_front();
        total++;
        if (!ok || idx !== e.idx || res0 !== e.res) begin
            bad++;
            $display("FAIL rexec_res: got ok=%0d idx=%b res0=%h want idx=%b %h", ok, idx, res0, e.idx, e.res);
        end
        tick();
    endtask

    task automatic test_full_width();
        exp_t e;
        logic idx;
        bit   ok;
        do_reset();
        req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0000; sel0 = 4'hC;
        sb_q.push_back('{1'b0, 32'hFFFF_FFFF});
        wait_done(idx, ok);
        req0 = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (!ok || idx !== e.idx || res0 !== e.res) begin
            bad++;
            $display("FAIL full_width: got ok=%0d idx=%b res0=%h want idx=%b %h", ok, idx, res0, e.idx, e.res);
        end
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_empty: got %0d entries want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_operand_hold();
        test_late_req();
        test_reset_exec();
        test_full_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
